// File: rtl/gemm_pkg.sv
// Shared types and defaults for the GEMM host-side controller.
// A frame is alpha, beta, then A, B and C in row-major order.
package gemm_pkg;
  localparam int GEMM_DATA_WIDTH    = 64;
  localparam int GEMM_MATRIX_WIDTH  = 4;
  localparam int GEMM_MATRIX_HEIGHT = 4;

  typedef enum logic [1:0] {LOAD, START, WAIT, UNLOAD} host_state_t;

  function automatic int frame_len(input int h, input int w);
    return 2 + 3 * h * w;
  endfunction
endpackage

// File: rtl/gemm_result_serializer.sv
// Captures the GEMM result on done and streams it row-major over valid/ready.
// The first element is presented in the cycle after capture.
module gemm_result_serializer import gemm_pkg::*; #(
  parameter int DATA_WIDTH = GEMM_DATA_WIDTH,
  parameter int NUM_ELEM   = GEMM_MATRIX_WIDTH * GEMM_MATRIX_HEIGHT
) (
  input  logic                                iclk,
  input  logic                                irst_n,
  input  logic                                icapture,
  input  logic [NUM_ELEM-1:0][DATA_WIDTH-1:0] iresult,
  output logic                                om_valid,
  input  logic                                im_ready,
  output logic [DATA_WIDTH-1:0]               om_data,
  output logic                                om_last,
  output logic                                odone
);
  localparam int IDX_W = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;

  logic [NUM_ELEM-1:0][DATA_WIDTH-1:0] res_q;
  logic [IDX_W-1:0]                    idx;  // next element to present
  logic                                hs;

  assign hs    = om_valid && im_ready;
  assign odone = hs && om_last;

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      res_q    <= '0;
      idx      <= '0;
      om_valid <= 1'b0;
      om_data  <= '0;
      om_last  <= 1'b0;
    end else if (icapture) begin
      res_q    <= iresult;
      om_data  <= iresult[0];
      om_last  <= (NUM_ELEM == 1);
      om_valid <= 1'b1;
      idx      <= IDX_W'(1);
    end else if (hs) begin
      if (om_last) begin
        om_valid <= 1'b0;
        om_last  <= 1'b0;
        idx      <= '0;
      end else begin
        om_data <= res_q[idx];
        om_last <= (idx == IDX_W'(NUM_ELEM - 1));
        idx     <= idx + IDX_W'(1);
      end
    end
  end
endmodule

// File: rtl/gemm_host_ctrl.sv
// Host initiator for gemm_top: loads a word stream into the operand registers,
// starts the GEMM, waits for done under a watchdog and streams the result back.
module gemm_host_ctrl import gemm_pkg::*; #(
  parameter int DATA_WIDTH    = GEMM_DATA_WIDTH,
  parameter int MATRIX_WIDTH  = GEMM_MATRIX_WIDTH,
  parameter int MATRIX_HEIGHT = GEMM_MATRIX_HEIGHT,
  parameter int TIMEOUT       = 1024
) (
  input  logic                                                     iclk,
  input  logic                                                     irst_n,
  input  logic                                                     is_valid,
  output logic                                                     os_ready,
  input  logic [DATA_WIDTH-1:0]                                    is_data,
  input  logic                                                     is_last,
  output logic [DATA_WIDTH-1:0]                                    oalpha,
  output logic [DATA_WIDTH-1:0]                                    obeta,
  output logic [MATRIX_HEIGHT-1:0][MATRIX_WIDTH-1:0][DATA_WIDTH-1:0] oa_matrix,
  output logic [MATRIX_HEIGHT-1:0][MATRIX_WIDTH-1:0][DATA_WIDTH-1:0] ob_matrix,
  output logic [MATRIX_HEIGHT-1:0][MATRIX_WIDTH-1:0][DATA_WIDTH-1:0] oc_matrix,
  output logic                                                     ostart,
  input  logic                                                     igemm_busy,
  input  logic                                                     igemm_done,
  input  logic [MATRIX_HEIGHT-1:0][MATRIX_WIDTH-1:0][DATA_WIDTH-1:0] iresult_matrix,
  output logic                                                     om_valid,
  input  logic                                                     im_ready,
  output logic [DATA_WIDTH-1:0]                                    om_data,
  output logic                                                     om_last,
  output logic                                                     obusy,
  output logic                                                     oerr
);
  localparam int NE    = MATRIX_HEIGHT * MATRIX_WIDTH;
  localparam int N     = frame_len(MATRIX_HEIGHT, MATRIX_WIDTH);
  localparam int CNT_W = $clog2(N);
  localparam int IDX_W = (NE > 1) ? $clog2(NE) : 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] A_BASE    = CNT_W'(2);
  localparam logic [CNT_W-1:0] B_BASE    = CNT_W'(2 + NE);
  localparam logic [CNT_W-1:0] C_BASE    = CNT_W'(2 + 2 * NE);

  typedef logic [NE-1:0][DATA_WIDTH-1:0] mat_flat_t;

  host_state_t      state, state_nxt;
  logic [CNT_W-1:0] wcnt;
  logic [TO_W-1:0]  tcnt;
  mat_flat_t        a_q, b_q, c_q;
  logic [CNT_W-1:0] off;
  logic [IDX_W-1:0] eidx;
  logic             accept, frame_err, timeout_hit, res_capture, res_done;
  logic             unused_busy;

  assign unused_busy = igemm_busy;

  // os_ready is only ever high in LOAD, so accept implies LOAD.
  assign accept      = is_valid && os_ready;
  assign frame_err   = accept && ((wcnt == LAST_WORD) != is_last);
  assign res_capture = (state == WAIT) && igemm_done;
  assign timeout_hit = (state == WAIT) && !igemm_done && (tcnt == TO_W'(TIMEOUT - 1));

  always_comb begin
    off = wcnt - A_BASE;
    if (wcnt >= C_BASE)      off = wcnt - C_BASE;
    else if (wcnt >= B_BASE) off = wcnt - B_BASE;
  end
  assign eidx = off[IDX_W-1:0];

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (accept && (wcnt == LAST_WORD) && is_last) state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT:    if (res_capture) state_nxt = UNLOAD;
               else if (timeout_hit) state_nxt = LOAD;
      UNLOAD:  if (res_done) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state    <= LOAD;
      wcnt     <= '0;
      tcnt     <= '0;
      os_ready <= 1'b0;
      ostart   <= 1'b0;
      obusy    <= 1'b0;
      oerr     <= 1'b0;
    end else begin
      state    <= state_nxt;
      os_ready <= (state_nxt == LOAD);
      obusy    <= (state_nxt != LOAD);
      ostart   <= (state_nxt == START);
      oerr     <= frame_err || timeout_hit;
      if (accept) wcnt <= ((wcnt == LAST_WORD) || is_last) ? '0 : wcnt + CNT_W'(1);
      tcnt <= ((state == WAIT) && (state_nxt == WAIT)) ? tcnt + TO_W'(1) : '0;
    end
  end

  // Written only on accepted words; a discarded frame leaves partial contents.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      oalpha <= '0;
      obeta  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
    end else if (accept) begin
      if (wcnt == '0)           oalpha     <= is_data;
      else if (wcnt == A_BASE - CNT_W'(1)) obeta <= is_data;
      else if (wcnt < B_BASE)   a_q[eidx]  <= is_data;
      else if (wcnt < C_BASE)   b_q[eidx]  <= is_data;
      else                      c_q[eidx]  <= is_data;
    end
  end

  assign oa_matrix = a_q;
  assign ob_matrix = b_q;
  assign oc_matrix = c_q;

  gemm_result_serializer #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_ELEM   (NE)
  ) u_ser (
    .iclk     (iclk),
    .irst_n   (irst_n),
    .icapture (res_capture),
    .iresult  (iresult_matrix),
    .om_valid (om_valid),
    .im_ready (im_ready),
    .om_data  (om_data),
    .om_last  (om_last),
    .odone    (res_done)
  );
endmodule

// File: doc/gemm_host_ctrl.md
# gemm_host_ctrl

Host-side initiator for `gemm_top`. It accepts one valid/ready word stream carrying alpha, beta and the A, B and C matrices, and drives them onto the GEMM's parallel matrix ports. It then pulses start, waits for done (with a watchdog) and captures the result matrix. Finally it serialises the result back out as a valid/ready stream, so a DMA or host bridge can feed and drain the GEMM one word at a time.

## Interface
Parameters:
- `DATA_WIDTH`, 64, element/word width (signed two's complement)
- `MATRIX_WIDTH`, 4, columns per matrix
- `MATRIX_HEIGHT`, 4, rows per matrix
- `TIMEOUT`, 1024, maximum WAIT cycles before abort

Ports:
- `iclk`  in  1  clock; single clock domain
- `irst_n`  in  1  reset, asynchronous, active-low
- `is_valid`  in  1  input word valid
- `os_ready`  out  1  input word accepted when `is_valid && os_ready`
- `is_data`  in  DATA_WIDTH  input word
- `is_last`  in  1  marks final word of input frame
- `oalpha`, `obeta`  out  DATA_WIDTH each  scalars to GEMM
- `oa_matrix`, `ob_matrix`, `oc_matrix`  out  [H][W]×DATA_WIDTH  operands to GEMM
- `ostart`  out  1  one-cycle GEMM start pulse
- `igemm_busy`  in  1  GEMM busy; status only, not used for control
- `igemm_done`  in  1  GEMM done
- `iresult_matrix`  in  [H][W]×DATA_WIDTH  GEMM result
- `om_valid`  out  1  result word valid
- `im_ready`  in  1  downstream ready
- `om_data`  out  DATA_WIDTH  result word
- `om_last`  out  1  final result word
- `obusy`  out  1  high in any state except LOAD
- `oerr`  out  1  one-cycle error pulse

## Operation
- Frame order: alpha, beta, A row-major, B row-major, C row-major. Frame length N = 2 + 3·H·W; N = 50 for 4×4.
- States:
  - LOAD: accept words; the word counter selects the destination register.
  - START: `ostart` = 1 for exactly one cycle.
  - WAIT: count cycles; sample `igemm_done`.
  - UNLOAD: stream the captured result.
- LOAD transitions:
  - Word N−1 accepted with `is_last` = 1 → START.
  - `is_last` = 1 on any earlier word → frame discarded, counter := 0, `oerr` pulse, stay in LOAD.
  - Word N−1 accepted with `is_last` = 0 → same discard and `oerr`.
- Operand registers update only on accepted words. They are held constant from START through the end of UNLOAD. A discarded frame leaves partial contents; they are never started.
- WAIT transitions:
  - `igemm_done` = 1 → capture `iresult_matrix` into a local register, go to UNLOAD.
  - Counter reaches TIMEOUT without done → `oerr` pulse, go to LOAD.
  - `igemm_done` is ignored outside WAIT.
- UNLOAD: emit H·W words row-major from the captured copy. `om_last` is asserted with element [H−1][W−1]. After the last handshake, go to LOAD.
- Output stream rules: `om_data`/`om_last` stay stable while `om_valid && !im_ready`. `om_valid` never drops without a handshake.
- Widths: word counter $clog2(N); result index $clog2(H·W); timeout counter $clog2(TIMEOUT+1). No arithmetic on data.

## Timing
- Reset values (immediate on `irst_n` low, any state):
  - state = LOAD; all counters 0.
  - `os_ready`, `ostart`, `om_valid`, `om_last`, `obusy`, `oerr` = 0.
  - All matrices, alpha, beta, `om_data` = 0.
- `os_ready` is registered: 0 in reset, 1 from the first rising edge after release, 0 outside LOAD.
- Input throughput is 1 word/cycle. If the last word is accepted at edge t, `ostart` = 1 in cycle t+1 (START) and WAIT begins at t+2.
- If done is sampled at edge d in WAIT: `om_valid` = 1 with element [0][0] in cycle d+1.
- Timeout: `oerr` is asserted in the cycle after the TIMEOUT-th WAIT cycle.
- Output throughput is 1 word/cycle when `im_ready` is held high. `os_ready` = 1 in the cycle after the last output handshake.
- Reset mid-operation aborts everything, including a pending output word; nothing resumes.

## Structure
- Package `gemm_pkg`:
  - state enum `host_state_t` {LOAD, START, WAIT, UNLOAD}
  - `function frame_len(h, w)`
  - shared DATA_WIDTH/MATRIX_* defaults
- Sub-module `gemm_result_serializer`: capture-on-done register plus row-major valid/ready emitter with last flag. The top holds the input FSM, operand registers and watchdog.

## Test plan
- 4×4 nominal: stream alpha = 1, beta = 0, A = I, B = 1..16, C = 0 with `is_last` on word 50. A stub asserts done 8 cycles after `ostart` with result[i][j] = 100+4i+j → `ostart` exactly 1 cycle, `oalpha` = 1, `ob_matrix[3][3]` = 16; output 100..115 in order, `om_last` only on 115.
- Backpressure: `im_ready` pattern 1,0,1,0… → each word held while not ready, 16 words, no duplicates or drops, `os_ready` high after word 16.
- Early last: `is_last` on word 20 → `oerr` one cycle, no `ostart`. A following valid 50-word frame completes normally.
- Missing last: 50 words without `is_last` → `oerr`, no `ostart`, `os_ready` stays 1.
- Timeout: TIMEOUT = 16, stub never asserts done → `oerr` after 16 WAIT cycles, back in LOAD, `obusy` = 0.
- Reset mid-UNLOAD: `irst_n` low after 5 result handshakes → all outputs 0 immediately. `os_ready` = 1 one edge after release; a new frame runs clean.
